// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: frame size, FSM state encoding
// and the mid-bit offset helper.
package uart_rx_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_STOP    = 3'd3,
        S_CLEANUP = 3'd4
    } rx_state_t;

    // Cycles from the start-bit edge to the centre of the start bit.
    function automatic int half_bit_count(input int clks_per_bit);
        return (clks_per_bit - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs. Resets to RESET_VAL so a
// released reset presents an idle line rather than a spurious transition.
module uart_rx_sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, 1 stop, no parity.
// The serial input is synchronised, the start bit is found on a falling edge
// and re-checked at its centre, then every bit is sampled at mid-bit.
// A good stop bit yields a 1-cycle o_Rx_DV with the byte; a low stop bit
// yields a 1-cycle o_Rx_Frame_Err and the byte is discarded.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 48
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [7:0] HALF       = 8'(half_bit_count(CLKS_PER_BIT));
    localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_INDEX = 3'(DATA_BITS - 1);

    logic       rx_s;
    logic       rx_prev_r;
    logic       fall_s;

    rx_state_t  state_r, state_s;
    logic [7:0] count_r, count_s;
    logic [2:0] index_r, index_s;
    logic [7:0] data_r, data_s;
    logic [7:0] byte_s;
    logic       dv_s;
    logic       err_s;
    logic       active_s;

    uart_rx_sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_n),
        .d     (i_Rx_Serial),
        .q     (rx_s)
    );

    // Previous synchronised line value; resets high so release never looks like a start edge
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            rx_prev_r <= 1'b1;
        end else begin
            rx_prev_r <= rx_s;
        end
    end

    // A start is only recognised on a high-to-low transition, so a stuck-low line cannot retrigger
    assign fall_s = rx_prev_r & ~rx_s;

    // Next-state, counter, shift and output decode
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        index_s  = index_r;
        data_s   = data_r;
        byte_s   = o_Rx_Byte;
        dv_s     = 1'b0;
        err_s    = 1'b0;
        active_s = o_Rx_Active;

        case (state_r)
            S_IDLE: begin
                count_s = 8'd0;
                index_s = 3'd0;
                if (fall_s) begin
                    state_s = S_START;
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_START: begin
                if (count_r == HALF) begin
                    count_s = 8'd0;
                    if (!rx_s) begin
                        active_s = 1'b1;
                        state_s  = S_DATA;
                    end else begin
                        // Line went back high before mid-start: treat as a glitch
                        state_s = S_IDLE;
                    end
                end else begin
                    count_s = count_r + 8'd1;
                end
            end

            S_DATA: begin
                if (count_r == LAST_COUNT) begin
                    count_s         = 8'd0;
                    data_s[index_r] = rx_s;
                    if (index_r == LAST_INDEX) begin
                        index_s = 3'd0;
                        state_s = S_STOP;
                    end else begin
                        index_s = index_r + 3'd1;
                    end
                end else begin
                    count_s = count_r + 8'd1;
                end
            end

            S_STOP: begin
                if (count_r == LAST_COUNT) begin
                    count_s  = 8'd0;
                    active_s = 1'b0;
                    state_s  = S_CLEANUP;
                    if (rx_s) begin
                        byte_s = data_r;
                        dv_s   = 1'b1;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    count_s = count_r + 8'd1;
                end
            end

            S_CLEANUP: begin
                state_s = S_IDLE;
            end

            default: begin
                state_s  = S_IDLE;
                count_s  = 8'd0;
                index_s  = 3'd0;
                active_s = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r        <= S_IDLE;
            count_r        <= 8'd0;
            index_r        <= 3'd0;
            data_r         <= 8'd0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'd0;
            o_Rx_Frame_Err <= 1'b0;
            o_Rx_Active    <= 1'b0;
        end else begin
            state_r        <= state_s;
            count_r        <= count_s;
            index_r        <= index_s;
            data_r         <= data_s;
            o_Rx_DV        <= dv_s;
            o_Rx_Byte      <= byte_s;
            o_Rx_Frame_Err <= err_s;
            o_Rx_Active    <= active_s;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at the default 48 clocks per bit.
// A timing model derived from the pin history predicts every output on
// every cycle; directed scenarios add hand-computed literal checks.
module tb_uart_rx;

    localparam int CPB  = 48;
    localparam int HALF = (CPB - 1) / 2;
    localparam int MAXE = 32768;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_line;
    logic       dv;
    logic [7:0] rx_byte;
    logic       ferr;
    logic       active;

    int tests = 0;
    int fails = 0;

    // Model state
    bit         pin_hist [MAXE];
    int         edge_n = 0;
    bit         m_busy = 1'b0;
    bit         m_active = 1'b0;
    bit         m_dv = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] m_bits = 8'h00;
    int         m_ready = 0;
    int         m_vedge = 0;

    // Observation counters
    int         dv_count = 0;
    int         err_count = 0;
    bit         active_seen = 1'b0;
    int         first_dv_edge = -1;
    logic [7:0] got_bytes [$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx_line),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_obs();
        dv_count      = 0;
        err_count     = 0;
        active_seen   = 1'b0;
        first_dv_edge = -1;
        got_bytes.delete();
    endtask

    task automatic hold(input logic level, input int cycles);
        rx_line = level;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_bit);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop_bit, CPB);
        rx_line = 1'b1;
    endtask

    // Model: bit n of a frame is the pin value two edges before the edge
    // start_centre + (n+1)*CPB; the stop bit is the tenth such sample.
    initial begin : model
        int n;
        for (int i = 0; i < MAXE; i++) pin_hist[i] = 1'b1;
        forever begin
            @(posedge clk);
            if (edge_n < MAXE) pin_hist[edge_n] = rst_n ? rx_line : 1'b1;
            m_dv  = 1'b0;
            m_err = 1'b0;
            if (!rst_n) begin
                m_busy   = 1'b0;
                m_active = 1'b0;
                m_byte   = 8'h00;
                m_ready  = 0;
            end else if (edge_n >= 3 && edge_n < MAXE) begin
                if (!m_busy) begin
                    if (edge_n >= m_ready && pin_hist[edge_n-3] && !pin_hist[edge_n-2]) begin
                        m_busy  = 1'b1;
                        m_vedge = edge_n + 1 + HALF;
                    end
                end else if (edge_n == m_vedge) begin
                    if (pin_hist[edge_n-2]) begin
                        m_busy  = 1'b0;
                        m_ready = edge_n + 1;
                    end else begin
                        m_active = 1'b1;
                    end
                end else if (m_active && edge_n > m_vedge && (edge_n - m_vedge) % CPB == 0) begin
                    n = (edge_n - m_vedge) / CPB;
                    if (n <= 8) begin
                        m_bits[3'(n-1)] = pin_hist[edge_n-2];
                    end else begin
                        m_active = 1'b0;
                        m_busy   = 1'b0;
                        m_ready  = edge_n + 2;
                        if (pin_hist[edge_n-2]) begin
                            m_byte = m_bits;
                            m_dv   = 1'b1;
                        end else begin
                            m_err = 1'b1;
                        end
                    end
                end
            end
            edge_n++;
        end
    end

    // Compare every cycle against the model and gather observations
    initial begin : compare
        forever begin
            @(posedge clk);
            #1;
            tests++;
            if ({active, dv, ferr, rx_byte} !== {m_active, m_dv, m_err, m_byte}) begin
                fails++;
                $display("FAIL cycle_model edge %0d: act/dv/err/byte got %b/%b/%b/%h expected %b/%b/%b/%h",
                         edge_n - 1, active, dv, ferr, rx_byte, m_active, m_dv, m_err, m_byte);
            end
            if (dv) begin
                dv_count++;
                got_bytes.push_back(rx_byte);
                if (first_dv_edge < 0) first_dv_edge = edge_n - 1;
            end
            if (ferr) err_count++;
            if (active) active_seen = 1'b1;
        end
    end

    initial begin : stim
        logic [7:0] frames [10];
        int e0;
        frames = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h7E, 8'hC3, 8'h96, 8'h3C};

        rst_n   = 1'b0;
        rx_line = 1'b1;
        repeat (4) @(negedge clk);
        check("reset_outputs", int'({active, dv, ferr, rx_byte}), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // 1: two good frames
        clear_obs();
        send(8'h55, 1'b1);
        send(8'hA3, 1'b1);
        hold(1'b1, 2 * CPB);
        check("t1_dv_count", dv_count, 2);
        check("t1_err_count", err_count, 0);
        check("t1_byte_out", int'(rx_byte), 8'hA3);
        if (got_bytes.size() == 2) begin
            check("t1_byte0", int'(got_bytes[0]), 8'h55);
            check("t1_byte1", int'(got_bytes[1]), 8'hA3);
        end

        // 2: short low glitch on idle line
        clear_obs();
        hold(1'b0, 3);
        hold(1'b1, 3 * CPB);
        check("t2_dv_count", dv_count, 0);
        check("t2_err_count", err_count, 0);
        check("t2_active_seen", int'(active_seen), 0);

        // 3: framing error keeps previous byte
        clear_obs();
        send(8'h3C, 1'b0);
        hold(1'b1, 2 * CPB);
        check("t3_err_count", err_count, 1);
        check("t3_dv_count", dv_count, 0);
        check("t3_byte_held", int'(rx_byte), 8'hA3);

        // 4: break for 40 bit-times, then a good frame
        clear_obs();
        hold(1'b0, 40 * CPB);
        hold(1'b1, 2 * CPB);
        send(8'h81, 1'b1);
        hold(1'b1, 2 * CPB);
        check("t4_err_count", err_count, 1);
        check("t4_dv_count", dv_count, 1);
        check("t4_byte", int'(rx_byte), 8'h81);

        // 5: reset during data bit 4 of 0xF0, then 0x0F
        clear_obs();
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(1'b0, CPB);
        hold(1'b1, CPB / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_reset_byte", int'(rx_byte), 0);
        check("t5_reset_active", int'(active), 0);
        rst_n = 1'b1;
        hold(1'b1, 3 * CPB);
        send(8'h0F, 1'b1);
        hold(1'b1, 2 * CPB);
        check("t5_dv_count", dv_count, 1);
        check("t5_err_count", err_count, 0);
        check("t5_byte", int'(rx_byte), 8'h0F);

        // 6: latency and 10 back-to-back frames
        clear_obs();
        e0 = edge_n;
        for (int f = 0; f < 10; f++) send(frames[f], 1'b1);
        hold(1'b1, 2 * CPB);
        check("t6_latency", first_dv_edge - e0, 458);
        check("t6_dv_count", dv_count, 10);
        check("t6_err_count", err_count, 0);
        if (got_bytes.size() == 10) begin
            for (int f = 0; f < 10; f++) check("t6_byte", int'(got_bytes[f]), int'(frames[f]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
